// File: rtl/rd_logic_pkg.sv
// rd_logic_pkg: frame-buffer constants and read-engine state encoding
package rd_logic_pkg;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;
  localparam int BURST_WORDS_DEF = 64;
  typedef enum logic [2:0] {IDLE, WAIT_BUF, REQ, CMD, DATA, DONE} rd_state_t;
endpackage

// File: rtl/rd_logic_frame_sel.sv
// rd_frame_sel: tracks the writer's most recently completed frame
module rd_frame_sel
  import rd_logic_pkg::*;
#(
  parameter int PTR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_writing,
  input  logic [PTR_WIDTH-1:0] iv_wr_frame_ptr,
  input  logic [PTR_WIDTH-1:0] iv_frame_depth,
  input  logic                 clr,
  output logic [PTR_WIDTH-1:0] last_ptr,
  output logic                 frame_valid
);
  logic writing_d;
  logic fall;
  assign fall = writing_d & ~i_writing;
  // a new completion outranks the clear issued when a read starts
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      writing_d   <= 1'b0;
      last_ptr    <= '0;
      frame_valid <= 1'b0;
    end else begin
      writing_d   <= i_writing;
      if (fall) last_ptr <= (iv_wr_frame_ptr > iv_frame_depth) ? '0 : iv_wr_frame_ptr;
      frame_valid <= fall | (frame_valid & ~clr);
    end
endmodule

// File: rtl/rd_logic.sv
// rd_logic: frame-buffer read engine issuing burst reads on MCB port 3 into the back buffer
module rd_logic
  import rd_logic_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PTR_WIDTH   = 2,
  parameter int BURST_WORDS = BURST_WORDS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rd_enable,
  input  logic [PTR_WIDTH-1:0]  iv_frame_depth,
  input  logic [18:0]           iv_frame_size,
  input  logic [PTR_WIDTH-1:0]  iv_wr_frame_ptr,
  input  logic                  i_writing,
  output logic [PTR_WIDTH-1:0]  ov_rd_frame_ptr,
  output logic [18:0]           ov_rd_addr,
  output logic                  o_reading,
  output logic                  o_rd_req,
  input  logic                  i_rd_ack,
  input  logic                  i_calib_done,
  output logic                  o_p3_cmd_en,
  output logic [2:0]            ov_p3_cmd_instr,
  output logic [5:0]            ov_p3_cmd_bl,
  output logic [29:0]           ov_p3_cmd_byte_addr,
  input  logic                  i_p3_cmd_full,
  input  logic                  i_p3_cmd_empty,
  output logic                  o_p3_rd_en,
  input  logic [DATA_WIDTH-1:0] iv_p3_rd_data,
  input  logic                  i_p3_rd_empty,
  output logic [DATA_WIDTH-1:0] ov_back_buf_din,
  output logic                  o_back_buf_wr_en,
  input  logic                  i_back_buf_pf
);
  localparam int CW = $clog2(BURST_WORDS);
  localparam logic [CW-1:0] LAST = CW'(BURST_WORDS - 1);
  rd_state_t state, state_n;
  logic [CW-1:0] wcnt;
  logic [18:0] size_m1;
  logic [PTR_WIDTH-1:0] last_ptr;
  logic frame_valid, start, unused_ok;
  assign unused_ok = i_p3_cmd_empty;
  assign ov_p3_cmd_instr = CMD_RD;
  assign ov_p3_cmd_bl = 6'(BURST_WORDS - 1);
  assign ov_p3_cmd_byte_addr = 30'({ov_rd_frame_ptr, ov_rd_addr, 8'h00});
  assign start = (state == IDLE) && (state_n == WAIT_BUF);
  rd_frame_sel #(.PTR_WIDTH(PTR_WIDTH)) u_frame_sel (
    .clk(clk), .reset(reset), .i_writing(i_writing), .iv_wr_frame_ptr(iv_wr_frame_ptr),
    .iv_frame_depth(iv_frame_depth), .clr(start), .last_ptr(last_ptr), .frame_valid(frame_valid)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    o_rd_req = 1'b0;
    o_p3_cmd_en = 1'b0;
    o_p3_rd_en = 1'b0;
    case (state)
      IDLE:     if (i_calib_done & i_rd_enable & frame_valid) state_n = WAIT_BUF;
      WAIT_BUF: if (!i_back_buf_pf) state_n = REQ;
      REQ: begin
        o_rd_req = 1'b1;
        if (i_rd_ack) state_n = CMD;
      end
      CMD: begin
        o_p3_cmd_en = !i_p3_cmd_full;
        if (!i_p3_cmd_full) state_n = DATA;
      end
      DATA: begin
        o_p3_rd_en = !i_p3_rd_empty;
        if (!i_p3_rd_empty && wcnt == LAST) state_n = (ov_rd_addr == size_m1) ? DONE : WAIT_BUF;
      end
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  // the back-buffer write trails the FIFO pop by one cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wcnt             <= '0;
      size_m1          <= '0;
      ov_rd_frame_ptr  <= '0;
      ov_rd_addr       <= '0;
      o_reading        <= 1'b0;
      ov_back_buf_din  <= '0;
      o_back_buf_wr_en <= 1'b0;
    end else begin
      o_back_buf_wr_en <= o_p3_rd_en;
      if (o_p3_rd_en) begin
        ov_back_buf_din <= iv_p3_rd_data;
        wcnt            <= wcnt + 1'b1;
      end
      if (start) begin
        ov_rd_frame_ptr <= last_ptr;
        ov_rd_addr      <= '0;
        size_m1         <= (iv_frame_size == 19'd0) ? 19'd0 : iv_frame_size - 19'd1;
        wcnt            <= '0;
        o_reading       <= 1'b1;
      end else if (state == DATA && state_n == WAIT_BUF) begin
        ov_rd_addr <= ov_rd_addr + 19'd1;
      end
      if (state_n == DONE) o_reading <= 1'b0;
    end
endmodule

// File: tb/tb_rd_logic.sv
// tb_rd_logic: directed frame-read scenarios checked against an MCB/back-buffer model
module tb_rd_logic;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_rd_enable = 1'b0;
  logic [1:0] iv_frame_depth = 2'd3;
  logic [18:0] iv_frame_size = 19'd1;
  logic [1:0] iv_wr_frame_ptr = 2'd0;
  logic i_writing = 1'b0;
  logic [1:0] ov_rd_frame_ptr;
  logic [18:0] ov_rd_addr;
  logic o_reading, o_rd_req, o_p3_cmd_en, o_p3_rd_en, o_back_buf_wr_en;
  logic i_rd_ack = 1'b0;
  logic i_calib_done = 1'b1;
  logic [2:0] ov_p3_cmd_instr;
  logic [5:0] ov_p3_cmd_bl;
  logic [29:0] ov_p3_cmd_byte_addr;
  logic i_p3_cmd_full = 1'b0;
  logic i_p3_cmd_empty = 1'b1;
  logic [31:0] iv_p3_rd_data = '0;
  logic i_p3_rd_empty = 1'b1;
  logic [31:0] ov_back_buf_din;
  logic i_back_buf_pf = 1'b0;

  rd_logic dut (
    .clk(clk), .reset(reset), .i_rd_enable(i_rd_enable), .iv_frame_depth(iv_frame_depth),
    .iv_frame_size(iv_frame_size), .iv_wr_frame_ptr(iv_wr_frame_ptr), .i_writing(i_writing),
    .ov_rd_frame_ptr(ov_rd_frame_ptr), .ov_rd_addr(ov_rd_addr), .o_reading(o_reading),
    .o_rd_req(o_rd_req), .i_rd_ack(i_rd_ack), .i_calib_done(i_calib_done),
    .o_p3_cmd_en(o_p3_cmd_en), .ov_p3_cmd_instr(ov_p3_cmd_instr), .ov_p3_cmd_bl(ov_p3_cmd_bl),
    .ov_p3_cmd_byte_addr(ov_p3_cmd_byte_addr), .i_p3_cmd_full(i_p3_cmd_full),
    .i_p3_cmd_empty(i_p3_cmd_empty), .o_p3_rd_en(o_p3_rd_en), .iv_p3_rd_data(iv_p3_rd_data),
    .i_p3_rd_empty(i_p3_rd_empty), .ov_back_buf_din(ov_back_buf_din),
    .o_back_buf_wr_en(o_back_buf_wr_en), .i_back_buf_pf(i_back_buf_pf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, n_cmd = 0, n_wr = 0, n_req = 0, rise_cyc = 0, last_req_cyc = 0;
  int first_lat = -1, cmd_gap = 0;
  bit ack_always = 1'b1, sparse = 1'b0;
  int ack_delay = 0, full_stall = 0, req_cnt = 0, full_cnt = 0;
  bit tog = 1'b0;
  bit s_pop = 1'b0, s_cmd = 1'b0, s_req = 1'b0, pending = 1'b0, pf_prev = 1'b0, rd_prev = 1'b0;
  logic [29:0] s_addr = '0;
  logic [29:0] exp_addr[$];
  logic [31:0] exp_words[$];
  logic [31:0] mq[$];
  logic [31:0] cw, dummy;
  logic [29:0] ca;

  function automatic logic [31:0] wd(input logic [29:0] a, input int k);
    return {a[29:8], 10'(k)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_burst(input logic [29:0] a);
    exp_addr.push_back(a);
    for (int k = 0; k < 64; k++) exp_words.push_back(wd(a, k));
  endtask

  task automatic begin_test();
    n_cmd = 0; n_wr = 0; n_req = 0; first_lat = -1; cmd_gap = 0;
  endtask

  task automatic writer_edge(input logic [1:0] p);
    i_writing = 1'b1;
    iv_wr_frame_ptr = p;
    step(1);
    i_writing = 1'b0;
  endtask

  task automatic wait_done(input int ncmd);
    int t = 0;
    while ((exp_addr.size() > 0 || exp_words.size() > 0) && t < 5000) begin
      step(1);
      t++;
    end
    step(3);
    chk("frame_in_time", 64'(t < 5000), 64'(1));
    chk("n_cmd", 64'(n_cmd), 64'(ncmd));
    chk("n_wr", 64'(n_wr), 64'(ncmd * 64));
    chk("reading_low", 64'(o_reading), 64'(0));
    i_rd_enable = 1'b0;
  endtask

  // MCB port 3 model: a queued burst per accepted command, served first-word-fall-through
  always @(posedge clk) begin
    #1;
    if (s_pop && mq.size() > 0) dummy = mq.pop_front();
    if (s_cmd) for (int k = 0; k < 64; k++) mq.push_back(wd(s_addr, k));
    full_cnt = (s_req && i_rd_ack) ? full_stall : (full_cnt > 0 ? full_cnt - 1 : 0);
    req_cnt = s_req ? req_cnt + 1 : 0;
    i_rd_ack = ack_always || (s_req && req_cnt >= ack_delay);
    i_p3_cmd_full = full_cnt > 0;
    tog = !tog;
    iv_p3_rd_data = (mq.size() > 0) ? mq[0] : 32'd0;
    i_p3_rd_empty = (mq.size() == 0) || (sparse && tog);
  end

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("rst_ctl", 64'({o_rd_req, o_p3_cmd_en, o_p3_rd_en, o_back_buf_wr_en, o_reading}), 64'(0));
      chk("rst_ptr", 64'({ov_rd_frame_ptr, ov_rd_addr}), 64'(0));
      chk("rst_addr", 64'(ov_p3_cmd_byte_addr), 64'(0));
      chk("rst_din", 64'(ov_back_buf_din), 64'(0));
      s_pop = 1'b0; s_cmd = 1'b0; s_req = 1'b0; pending = 1'b0; pf_prev = 1'b0; rd_prev = 1'b0;
    end else begin
      chk("instr", 64'(ov_p3_cmd_instr), 64'(3'b001));
      chk("bl", 64'(ov_p3_cmd_bl), 64'(63));
      chk("wr_latency", 64'(o_back_buf_wr_en), 64'(s_pop));
      if (o_back_buf_wr_en) begin
        n_wr++;
        chk("wr_expected", 64'(exp_words.size() > 0), 64'(1));
        if (exp_words.size() > 0) begin
          cw = exp_words.pop_front();
          chk("din", 64'(ov_back_buf_din), 64'(cw));
        end
      end
      chk("cmd_en", 64'(o_p3_cmd_en), 64'(pending && !i_p3_cmd_full));
      chk("req_in_cmd", 64'(o_rd_req && pending), 64'(0));
      chk("pop_empty", 64'(o_p3_rd_en && i_p3_rd_empty), 64'(0));
      if (o_rd_req && !s_req) chk("req_after_pf", 64'(pf_prev), 64'(0));
      if (o_reading && !rd_prev) rise_cyc = cyc;
      if (o_p3_cmd_en) begin
        n_cmd++;
        cmd_gap = cyc - last_req_cyc;
        if (first_lat < 0) first_lat = cyc - rise_cyc;
        chk("reading_in_cmd", 64'(o_reading), 64'(1));
        chk("cmd_expected", 64'(exp_addr.size() > 0), 64'(1));
        if (exp_addr.size() > 0) begin
          ca = exp_addr.pop_front();
          chk("cmd_addr", 64'(ov_p3_cmd_byte_addr), 64'(ca));
        end
        pending = 1'b0;
      end
      if (o_rd_req) begin
        n_req++;
        last_req_cyc = cyc;
        if (i_rd_ack) pending = 1'b1;
      end
      s_pop = o_p3_rd_en && !i_p3_rd_empty;
      s_cmd = o_p3_cmd_en;
      s_addr = ov_p3_cmd_byte_addr;
      s_req = o_rd_req;
      pf_prev = i_back_buf_pf;
      rd_prev = o_reading;
    end
  end

  initial begin
    int t, reqs;
    step(3);
    reset = 1'b0;
    step(2);

    // basic two-burst frame from pointer 2
    begin_test();
    iv_frame_depth = 2'd3; iv_frame_size = 19'd2; i_rd_enable = 1'b1;
    expect_burst(30'h1000_0000);
    expect_burst(30'h1000_0100);
    writer_edge(2'd2);
    wait_done(2);
    chk("start_latency", 64'(first_lat), 64'(2));

    // back-buffer pressure before the second burst
    begin_test();
    iv_frame_size = 19'd2; i_rd_enable = 1'b1;
    expect_burst(30'h0800_0000);
    expect_burst(30'h0800_0100);
    writer_edge(2'd1);
    t = 0;
    while (n_cmd < 1 && t < 200) begin step(1); t++; end
    i_back_buf_pf = 1'b1;
    t = 0;
    while (n_wr < 64 && t < 500) begin step(1); t++; end
    reqs = 0;
    for (int i = 0; i < 20; i++) begin step(1); reqs += int'(o_rd_req); end
    chk("req_while_pf", 64'(reqs), 64'(0));
    chk("held_reading", 64'(o_reading), 64'(1));
    i_back_buf_pf = 1'b0;
    wait_done(2);

    // ack delayed 10 cycles then cmd FIFO full for 5 cycles
    begin_test();
    ack_always = 1'b0; ack_delay = 10; full_stall = 5;
    iv_frame_size = 19'd1; i_rd_enable = 1'b1;
    expect_burst(30'h1800_0000);
    writer_edge(2'd3);
    wait_done(1);
    chk("req_cycles", 64'(n_req), 64'(11));
    chk("cmd_after_full", 64'(cmd_gap), 64'(6));
    ack_always = 1'b1; ack_delay = 0; full_stall = 0;

    // sparse read data
    begin_test();
    sparse = 1'b1; iv_frame_size = 19'd1; i_rd_enable = 1'b1;
    expect_burst(30'h0000_0000);
    writer_edge(2'd0);
    wait_done(1);
    sparse = 1'b0;

    // size 0 behaves as one burst
    begin_test();
    iv_frame_size = 19'd0; i_rd_enable = 1'b1;
    expect_burst(30'h1000_0000);
    writer_edge(2'd2);
    wait_done(1);

    // pointer beyond depth clamps to frame 0
    begin_test();
    iv_frame_depth = 2'd1; iv_frame_size = 19'd1; i_rd_enable = 1'b1;
    expect_burst(30'h0000_0000);
    writer_edge(2'd3);
    wait_done(1);
    iv_frame_depth = 2'd3;

    // writer edge coincides with leaving IDLE
    begin_test();
    iv_frame_size = 19'd1;
    writer_edge(2'd2);
    step(3);
    expect_burst(30'h1000_0000);
    expect_burst(30'h0800_0000);
    i_writing = 1'b1; iv_wr_frame_ptr = 2'd1;
    step(1);
    i_writing = 1'b0; i_rd_enable = 1'b1;
    wait_done(2);

    // reset in the middle of a burst
    begin_test();
    iv_frame_size = 19'd2; i_rd_enable = 1'b1;
    expect_burst(30'h1000_0000);
    expect_burst(30'h1000_0100);
    writer_edge(2'd2);
    t = 0;
    while (n_wr < 30 && t < 500) begin @(negedge clk); #1; t++; end
    reset = 1'b1;
    #1;
    chk("rst_now_reading", 64'(o_reading), 64'(0));
    chk("rst_now_pop", 64'(o_p3_rd_en), 64'(0));
    chk("rst_now_wr", 64'(o_back_buf_wr_en), 64'(0));
    chk("rst_now_addr", 64'(ov_p3_cmd_byte_addr), 64'(0));
    step(2);
    mq.delete(); exp_addr.delete(); exp_words.delete();
    reset = 1'b0;
    begin_test();
    step(40);
    chk("no_cmd_after_rst", 64'(n_cmd), 64'(0));
    iv_frame_size = 19'd1;
    expect_burst(30'h0800_0000);
    writer_edge(2'd1);
    wait_done(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rd_logic.md
# rd_logic

Frame-buffer read engine, the read-side counterpart of the frame-buffer write logic. It selects the most recently completed frame, arbitrates with the writer through a req/ack handshake, and issues 64-word read bursts on MCB port 3. Returned data is drained into the back-end buffer. It sits between the MCB read port and the back FIFO and runs in the frame-buffer clock domain.

## Interface
- DATA_WIDTH, 32, MCB/back-buffer data width
- PTR_WIDTH, 2, frame pointer width; legal range 1–3
- BURST_WORDS, 64, words per read burst; cmd_bl = BURST_WORDS-1
- clk  in  1  frame-buffer clock; the only clock
- reset  in  1  frame-buffer reset, asynchronous, active-high
- i_rd_enable  in  1  start enable, sampled only in IDLE
- iv_frame_depth  in  PTR_WIDTH  last valid frame index (0 = 1 frame)
- iv_frame_size  in  19  frame length in bursts; latched at frame start; 0 is treated as 1
- iv_wr_frame_ptr  in  PTR_WIDTH  writer frame pointer
- i_writing  in  1  writer busy
- ov_rd_frame_ptr  out  PTR_WIDTH  frame being read; reset 0
- ov_rd_addr  out  19  burst index within the frame; reset 0
- o_reading  out  1  frame read in progress; reset 0
- o_rd_req  out  1  arbitration request; reset 0
- i_rd_ack  in  1  arbitration grant
- i_calib_done  in  1  MCB calibration done
- o_p3_cmd_en  out  1  command push; reset 0
- ov_p3_cmd_instr  out  3  constant 3'b001 (read)
- ov_p3_cmd_bl  out  6  constant BURST_WORDS-1
- ov_p3_cmd_byte_addr  out  30  {zero pad, ov_rd_frame_ptr, ov_rd_addr, 8'h00}; reset 0
- i_p3_cmd_full  in  1  command FIFO full
- i_p3_cmd_empty  in  1  unused, kept for port symmetry
- o_p3_rd_en  out  1  MCB read FIFO pop; reset 0
- iv_p3_rd_data  in  DATA_WIDTH  first-word-fall-through data
- i_p3_rd_empty  in  1  MCB read FIFO empty
- ov_back_buf_din  out  DATA_WIDTH  back-buffer data; reset 0
- o_back_buf_wr_en  out  1  back-buffer write; reset 0
- i_back_buf_pf  in  1  back-buffer programmable full; asserted when fewer than BURST_WORDS free entries remain

## Operation
- Frame tracking:
  - A falling edge of i_writing (registered delay of one cycle) captures iv_wr_frame_ptr into last_ptr and sets frame_valid.
  - Leaving IDLE clears frame_valid.
  - If a set and a clear occur in the same cycle, the set wins: frame_valid stays 1 and last_ptr takes the new value.
- States: IDLE, WAIT_BUF, REQ, CMD, DATA, DONE.
- IDLE → WAIT_BUF when i_calib_done & i_rd_enable & frame_valid. On this transition:
  - ov_rd_frame_ptr ← last_ptr
  - ov_rd_addr ← 0
  - iv_frame_size is latched
  - o_reading is set
- WAIT_BUF → REQ when !i_back_buf_pf.
- REQ: o_rd_req = 1 until i_rd_ack is sampled high, then → CMD with o_rd_req = 0.
- CMD: o_p3_cmd_en pulses for exactly one cycle, in the first cycle where !i_p3_cmd_full; then → DATA.
- DATA:
  - o_p3_rd_en = !i_p3_rd_empty, combinational in state DATA.
  - A 6-bit word counter increments on each pop.
  - When the pop with count == BURST_WORDS-1 occurs:
    - If ov_rd_addr == size-1 → DONE.
    - Otherwise ov_rd_addr increments and the state → WAIT_BUF.
- DONE: o_reading cleared; → IDLE after one cycle.
- Deasserting i_rd_enable mid-frame has no effect; the frame always completes.
- If i_calib_done drops mid-frame, the block still finishes the current burst.
- Reset mid-operation: all registers return to reset values immediately, frame_valid = 0, and no partial burst is resumed.
- iv_frame_depth bounds the pointer: a captured pointer greater than iv_frame_depth is clamped to 0.

## Timing
- Back-buffer write is registered: a pop in cycle n gives o_back_buf_wr_en = 1 in cycle n+1, with ov_back_buf_din = iv_p3_rd_data from cycle n.
- Start latency, with all conditions true: IDLE (t0) → WAIT_BUF (t1) → REQ (t2) → CMD (t3 at the earliest after ack) → cmd_en at t3.
- Per-burst overhead: 3 cycles plus the wait time on ack, cmd_full and rd_empty.
- o_p3_cmd_en is never high for 2 consecutive cycles.
- o_rd_req never overlaps o_p3_cmd_en.

## Structure
- Shared package (frame-buffer package) holds:
  - MCB instruction constants (CMD_RD = 3'b001, CMD_WR = 3'b000)
  - BURST_WORDS default
  - the state encoding
- One sub-module, rd_frame_sel: i_writing edge detect, last_ptr/frame_valid capture and clamp.
- The FSM, counters and MCB/back-buffer datapath stay in rd_logic.

## Test plan
- Basic frame read: PTR_WIDTH=2, depth=3, size=2. Writer drops i_writing with wr_ptr=2 → exactly 2 read commands at byte addresses (2<<27)|0x000 and (2<<27)|0x100, 128 back-buffer writes in order, then o_reading falls.
- Back-pressure: i_back_buf_pf held high for 20 cycles before the second burst → no o_rd_req until pf falls; word count remains 128.
- Handshake stalls: i_rd_ack delayed by 10 cycles, then i_p3_cmd_full held for 5 cycles → one cmd_en pulse only, issued in the first cycle with !cmd_full.
- Sparse MCB data: i_p3_rd_empty toggles every other cycle → 64 pops per burst and data order preserved with a 1-cycle write latency.
- Boundaries:
  - size=0 → one burst.
  - A writer edge in the same cycle as the IDLE exit with wr_ptr=1 → frame_valid stays 1 and the next frame read uses ptr 1.
  - Captured ptr=3 with depth=1 → reads ptr 0.
- Reset asserted mid-DATA after 30 words → all outputs return to reset values in the same cycle. After release, no command is issued until a new writer edge.
